// File: rtl/pipelined_carry_adder.sv
// W-bit add/subtract unit whose carry chain is cut into STAGES registered chunks.
// It uses a single global pipeline enable for valid/ready flow control.
module pipelined_carry_adder #(
  parameter int W      = 64,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = W / STAGES;

  // Each stage rotates its word right by one chunk. The operand chunk leaves
  // at the bottom and the finished sum chunk enters at the top, so after
  // STAGES rotations the word holds the sum in place.
  logic [W-1:0] r_q [0:STAGES];
  logic [W-1:0] b_q [0:STAGES-1];
  logic         c_q [0:STAGES];
  logic         v_q [0:STAGES];
  logic         ovf_q;

  logic [W-1:0]  r_nx [1:STAGES];
  logic          c_nx [1:STAGES];
  logic          ovf_nx;
  logic [CW-1:0] s_ch;
  logic          advance;

  assign advance   = ~v_q[STAGES] | out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES];
  assign sum       = r_q[STAGES];
  assign cout      = c_q[STAGES];
  assign ovf       = ovf_q;

  always_comb begin
    ovf_nx = 1'b0;
    s_ch   = '0;
    for (int unsigned k = 1; k <= STAGES; k++) begin
      {c_nx[k], s_ch} = {1'b0, r_q[k-1][CW-1:0]} + {1'b0, b_q[k-1][CW-1:0]}
                      + {{CW{1'b0}}, c_q[k-1]};
      r_nx[k] = r_q[k-1] >> CW;
      r_nx[k][W-CW +: CW] = s_ch;
      // a^b^s at the MSB recovers the carry into it.
      if (k == STAGES)
        ovf_nx = c_nx[k] ^ r_q[k-1][CW-1] ^ b_q[k-1][CW-1] ^ s_ch[CW-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k <= STAGES; k++) begin
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      for (int unsigned k = 0; k < STAGES; k++) b_q[k] <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        r_q[0] <= a;
        b_q[0] <= b ^ {W{sub}};
        c_q[0] <= cin ^ sub;
      end
      for (int unsigned k = 1; k <= STAGES; k++) begin
        r_q[k] <= r_nx[k];
        c_q[k] <= c_nx[k];
        v_q[k] <= v_q[k-1];
      end
      for (int unsigned k = 1; k < STAGES; k++) b_q[k] <= b_q[k-1] >> CW;
      ovf_q <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder: it covers reset, directed carry/overflow
// cases, streaming, bubbles, backpressure and reset while transactions are in flight.
module tb_pipelined_carry_adder;

  parameter int W      = 64;
  parameter int STAGES = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  pipelined_carry_adder #(.W(W), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int unsigned  acc;
    int unsigned  st;
  } exp_t;

  exp_t         sb [$];
  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  int unsigned  cyc = 0;
  int unsigned  stalls = 0;
  logic         dir_en = 1'b0;
  logic [W-1:0] dir_sum = '0;
  logic         dir_cout = 1'b0;
  logic         dir_ovf = 1'b0;
  logic         gen_done = 1'b0;

  localparam logic [W-1:0] MAXS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINS = {1'b1, {(W-1){1'b0}}};

  task automatic check(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic ts);
    exp_t         e;
    logic [W-1:0] be;
    logic [W:0]   t;
    be = tb ^ {W{ts}};
    t  = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, tc ^ ts};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (ta[W-1] == be[W-1]) && (t[W-1] != ta[W-1]);
    e.acc  = 0;
    e.st   = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshakes are sampled mid-cycle, where the inputs are stable.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("spurious_valid", {{(W+1){1'b0}}, out_valid}, '0);
          end else begin
            e = sb.pop_front();
            check("result", {cout, ovf, sum}, {e.cout, e.ovf, e.sum});
            check("latency", (W+2)'(cyc - e.acc), (W+2)'(STAGES + stalls - e.st));
          end
        end else begin
          check("stall_in_ready", {{(W+1){1'b0}}, in_ready}, '0);
          if (sb.size() != 0)
            check("hold", {cout, ovf, sum}, {sb[0].cout, sb[0].ovf, sb[0].sum});
          stalls++;
        end
      end
      if (in_valid && in_ready) begin
        if (dir_en) begin
          e.sum = dir_sum; e.cout = dir_cout; e.ovf = dir_ovf;
        end else begin
          e = model(a, b, cin, sub);
        end
        e.acc = cyc + 1;
        e.st  = stalls;
        sb.push_back(e);
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ts);
    logic ok;
    int   i;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      i++;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", {{(W+1){1'b0}}, ok}, {{(W+1){1'b0}}, 1'b1});
  endtask

  task automatic send_dir(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    dir_en = 1'b1; dir_sum = es; dir_cout = ec; dir_ovf = eo;
    send(ta, tb, tc, ts);
    dir_en = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 500) begin
      tick(1);
      i++;
    end
    check("drain", (W+2)'(sb.size()), '0);
  endtask

  initial begin
    // Reset held with traffic offered: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      a = rand_w(); b = rand_w(); cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
      check("rst_out_valid", {{(W+1){1'b0}}, out_valid}, '0);
      check("rst_outputs", {cout, ovf, sum}, '0);
      check("rst_in_ready", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, 1'b1});
    end
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < STAGES + 3; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {{(W+1){1'b0}}, out_valid}, '0);
    end
    tick(1);

    // Directed carry and overflow corners.
    send_dir('1, W'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0);
    drain();
    send_dir('0, '0, 1'b1, 1'b0, W'(1), 1'b0, 1'b0);
    drain();
    send_dir(W'(5), W'(7), 1'b0, 1'b1, ~W'(1), 1'b0, 1'b0);
    send_dir(MAXS, W'(1), 1'b0, 1'b0, MINS, 1'b0, 1'b1);
    send_dir(MINS, W'(1), 1'b0, 1'b1, MAXS, 1'b1, 1'b1);
    drain();

    // Back-to-back streaming, then with input bubbles.
    for (int i = 0; i < 1000; i++) send(rand_w(), rand_w(), 1'($urandom), 1'($urandom));
    drain();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick(1);
      else send(rand_w(), rand_w(), 1'($urandom), 1'($urandom));
    end
    drain();

    // Fill the pipeline against a stalled consumer, then release.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES + 1; i++) send(rand_w(), rand_w(), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {{(W+1){1'b0}}, in_ready}, '0);
      check("bp_out_valid", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, 1'b1});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    // Random consumer backpressure with random input bubbles.
    gen_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 4) == 0) tick(1);
          else send(rand_w(), rand_w(), 1'($urandom), 1'($urandom));
        end
        gen_done = 1'b1;
      end
      begin
        while (!gen_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with three transactions in flight discards them all.
    for (int i = 0; i < 3; i++) send(rand_w(), rand_w(), 1'($urandom), 1'($urandom));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < STAGES + 3; i++) begin
      @(negedge clk);
      check("midrst_quiet", {{(W+1){1'b0}}, out_valid}, '0);
    end
    tick(1);
    send(rand_w(), rand_w(), 1'($urandom), 1'($urandom));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule

// File: doc/pipelined_carry_adder.md
# pipelined_carry_adder

Parametrised, pipelined W-bit add/subtract unit with valid/ready flow control. It splits the carry chain into STAGES equal chunks, each resolved in its own pipeline stage with the inter-chunk carry registered. This gives single-cycle throughput at widths where a full ripple carry chain misses timing. It sits between the operand-generation logic and the result consumer, and supersedes the fixed-width, input/output-registered adder.

## Interface
- W, default 64: operand and sum width; must be ≥2 and divisible by STAGES.
- STAGES, default 4: number of carry-chunk pipeline stages, ≥1; chunk width CW = W/STAGES.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand transaction offered.
- in_ready  out  1  block can accept the offered transaction this cycle.
- a  in  W  operand A (unsigned or two's complement).
- b  in  W  operand B.
- cin  in  1  carry in (borrow in when sub=1).
- sub  in  1  0: a+b+cin; 1: a−b−cin.
- out_valid  out  1  result on sum/cout/ovf is valid.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  W  result, modulo 2^W.
- cout  out  1  carry out of bit W−1; for sub=1, 1 means no borrow.
- ovf  out  1  signed overflow: carry into bit W−1 XOR carry out of bit W−1.

## Operation
- Effective operands: b_eff = b XOR {W{sub}}, c0 = cin XOR sub; result = a + b_eff + c0.
- Stage 0 is the input register. It captures a, b_eff, c0, and a valid bit on acceptance (in_valid & in_ready).
- Stage k (1..STAGES) computes chunk k−1, bits [k·CW−1 : (k−1)·CW], by ripple from the registered carry of stage k−1.
  - It registers the chunk sum, all lower sum chunks, the unprocessed upper operand bits, the chunk carry-out, and a valid bit.
- Stage STAGES is the output register. It drives sum, cout, ovf, and out_valid directly; there is no combinational path from a/b to outputs.
- ovf is taken from the carry into the MSB in the last chunk.
- Flow control is a global pipeline enable: advance = ~out_valid | out_ready; in_ready = advance (combinational).
- When advance = 1, every stage loads from its predecessor. Stage 0 loads valid = in_valid & in_ready.
- When advance = 0, all stages hold.
- Bubbles propagate as valid = 0 entries. Results leave in acceptance order; no loss, no duplication.
- When out_valid = 1 and out_ready = 0, sum, cout, and ovf stay stable until the handshake completes.

## Timing
- Reset (rst = 1 at an edge): all valid bits = 0; all data registers, sum, cout, ovf = 0; out_valid = 0.
  - rst has priority: no transaction is accepted at an edge where rst = 1.
  - in_ready reads 1 during and after reset, because out_valid = 0.
- Latency: a transaction accepted at edge n is presented with out_valid = 1 after edge n+STAGES, assuming no stall. For STAGES=1 this is 2 edges including the acceptance edge.
- Throughput: one result per cycle while out_ready = 1.
- A stall of k cycles delays every in-flight transaction by exactly k cycles.
- Simultaneous output handshake and input acceptance in the same cycle is legal; a full pipeline with out_ready = 1 stays full.
- Reset mid-operation discards all in-flight transactions; out_valid is 0 from the first post-reset cycle until a new transaction reaches the output.
- out_ready is ignored while out_valid = 0.
- Wrap-around: sum is modulo 2^W. cout and ovf carry the out-of-range information.

## Test plan
Defaults W=64, STAGES=4 unless stated.
- **Reset:** hold rst for 3 cycles with in_valid=1 and random operands → out_valid=0, sum=0, cout=0, ovf=0, in_ready=1; no result ever emerges for those cycles.
- **Full carry ripple:** a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0, out_ready=1 → after 4 edges: sum=0, cout=1, ovf=0. Repeat with a=b=0, cin=1 → sum=1, cout=0.
- **Subtract and overflow:**
  - a=5, b=7, sub=1, cin=0 → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 → sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
  - a=64'h8000_0000_0000_0000, b=1, sub=1 → sum=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- **Streaming:** 1000 back-to-back random transactions, out_ready=1 → results match the reference model in order on consecutive cycles, first out_valid after 4 edges. Repeat with random in_valid bubbles.
- **Backpressure:** fill the pipeline, drop out_ready for 5 cycles → in_ready=0, sum/cout/ovf stable, stages hold. Raise out_ready → all results delivered once, in order. Repeat with random out_ready toggling.
- **Reset mid-flight, plus configuration sweep:**
  - 3 transactions in flight, pulse rst for 1 cycle → no out_valid until a new transaction completes.
  - Rerun all scenarios with (W=8, STAGES=1) and (W=32, STAGES=8).
